// File: rtl/dvbs2_pkg.sv
// Shared DVB-S2 mode-adaptation constants and types.
package dvbs2_pkg;

    localparam int unsigned TS_PKT_LEN   = 188;
    localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
    localparam logic [7:0]  CRC8_POLY    = 8'hD5;
    localparam logic [7:0]  TS_FIRST_CRC = 8'h00;

    // IDLE: waiting for a head byte; PKT: inside a packet
    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } ts_state_t;

endpackage

// File: rtl/dvbs2_crc8_byte.sv
// Combinational byte-parallel CRC-8 step, MSB first, no reflection.
// Ports:
//   crc_in  current CRC register
//   data    byte being absorbed
//   poly    generator polynomial (implicit x^8 term)
//   crc_c   CRC after absorbing data
module dvbs2_crc8_byte (
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    input  logic [7:0] poly,
    output logic [7:0] crc_c
);

    logic [7:0] acc;

    // Eight unrolled shift/XOR steps over (crc ^ data)
    always_comb begin
        acc = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            acc = acc[7] ? ((acc << 1) ^ poly) : (acc << 1);
        end
        crc_c = acc;
    end

endmodule

// File: rtl/ts_crc8_sync_replace.sv
// TS packet CRC-8 insertion: each packet's sync byte is replaced by the
// CRC-8 of the previous packet's payload; framing and sync errors flagged.
// Ports:
//   sys_clk, rst_n          clock, async active-low reset
//   fs_en                   sample enable; all state holds when 0
//   ts_in_head/vld/data     input byte stream
//   oe_head/oe/symbol_out   output byte stream, one enabled cycle later
//   sync_err                pulse: accepted head byte != SYNC_BYTE
//   len_err                 pulse: early head or valid dropped mid-packet
module ts_crc8_sync_replace
    import dvbs2_pkg::*;
#(
    parameter int unsigned PKT_LEN   = TS_PKT_LEN,
    parameter logic [7:0]  SYNC_BYTE = TS_SYNC_BYTE,
    parameter logic [7:0]  CRC_POLY  = CRC8_POLY,
    parameter logic [7:0]  FIRST_CRC = TS_FIRST_CRC
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       fs_en,
    input  logic       ts_in_head,
    input  logic       ts_in_vld,
    input  logic [7:0] ts_in_data,
    output logic       oe_head,
    output logic       oe,
    output logic [7:0] symbol_out,
    output logic       sync_err,
    output logic       len_err
);

    localparam int unsigned CNT_W = $clog2(PKT_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_LEN - 1);

    ts_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       crc_reg, crc_reg_n;
    logic [7:0]       crc_prev, crc_prev_n;
    logic             prev_valid, prev_valid_n;
    logic             oe_head_n, oe_n, sync_err_n, len_err_n;
    logic [7:0]       symbol_out_n;
    logic [7:0]       crc_upd_c;

    dvbs2_crc8_byte u_crc (
        .crc_in (crc_reg),
        .data   (ts_in_data),
        .poly   (CRC_POLY),
        .crc_c  (crc_upd_c)
    );

    // State and output registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            crc_reg    <= '0;
            crc_prev   <= '0;
            prev_valid <= 1'b0;
            oe_head    <= 1'b0;
            oe         <= 1'b0;
            symbol_out <= '0;
            sync_err   <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            crc_reg    <= crc_reg_n;
            crc_prev   <= crc_prev_n;
            prev_valid <= prev_valid_n;
            oe_head    <= oe_head_n;
            oe         <= oe_n;
            symbol_out <= symbol_out_n;
            sync_err   <= sync_err_n;
            len_err    <= len_err_n;
        end
    end

    // Next-state and output decode; everything holds while fs_en is low
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        crc_reg_n    = crc_reg;
        crc_prev_n   = crc_prev;
        prev_valid_n = prev_valid;
        oe_head_n    = oe_head;
        oe_n         = oe;
        symbol_out_n = symbol_out;
        sync_err_n   = sync_err;
        len_err_n    = len_err;

        if (fs_en) begin
            oe_head_n    = 1'b0;
            oe_n         = 1'b0;
            symbol_out_n = '0;
            sync_err_n   = 1'b0;
            len_err_n    = 1'b0;

            if (ts_in_vld && ts_in_head) begin
                // Any accepted head starts a packet; an early head also
                // invalidates the partial packet's CRC.
                oe_n       = 1'b1;
                oe_head_n  = 1'b1;
                sync_err_n = (ts_in_data != SYNC_BYTE);
                crc_reg_n  = '0;
                cnt_n      = CNT_W'(1);
                state_n    = PKT;
                if (state == PKT) begin
                    len_err_n    = 1'b1;
                    prev_valid_n = 1'b0;
                    symbol_out_n = FIRST_CRC;
                end else begin
                    symbol_out_n = prev_valid ? crc_prev : FIRST_CRC;
                end
            end else if (state == PKT) begin
                if (ts_in_vld) begin
                    oe_n         = 1'b1;
                    symbol_out_n = ts_in_data;
                    crc_reg_n    = crc_upd_c;
                    if (cnt == LAST_CNT) begin
                        crc_prev_n   = crc_upd_c;
                        prev_valid_n = 1'b1;
                        cnt_n        = '0;
                        state_n      = IDLE;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else begin
                    len_err_n    = 1'b1;
                    prev_valid_n = 1'b0;
                    cnt_n        = '0;
                    state_n      = IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ts_crc8_sync_replace.sv
// Randomized self-checking bench for ts_crc8_sync_replace with a
// packet-level reference model (payload queue + bit-serial CRC).
module tb_ts_crc8_sync_replace;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       fs_en;
    logic       ts_in_head;
    logic       ts_in_vld;
    logic [7:0] ts_in_data;
    logic       oe_head;
    logic       oe;
    logic [7:0] symbol_out;
    logic       sync_err;
    logic       len_err;

    ts_crc8_sync_replace dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .fs_en      (fs_en),
        .ts_in_head (ts_in_head),
        .ts_in_vld  (ts_in_vld),
        .ts_in_data (ts_in_data),
        .oe_head    (oe_head),
        .oe         (oe),
        .symbol_out (symbol_out),
        .sync_err   (sync_err),
        .len_err    (len_err)
    );

    always #5 sys_clk = ~sys_clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model state
    bit         m_in_pkt;
    bit         m_prev_ok;
    logic [7:0] m_prev_crc;
    logic [7:0] m_pay[$];
    logic       e_oe, e_head, e_serr, e_lerr;
    logic [7:0] e_sym;

    // Observation helpers
    logic [7:0] last_head;
    int         sync_cnt, len_cnt, gaps;
    bit         cont_mon;
    int         en_period;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Bit-serial MSB-first CRC-8, poly 0xD5, init 0, over a whole payload
    function automatic logic [7:0] crc_of(input logic [7:0] q[$]);
        logic [7:0] c = 8'h00;
        logic       fb;
        foreach (q[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ q[i][b];
                c  = c << 1;
                if (fb) c = c ^ 8'hD5;
            end
        end
        return c;
    endfunction

    task automatic model_reset();
        m_in_pkt = 0; m_prev_ok = 0; m_prev_crc = 8'h00; m_pay.delete();
        e_oe = 0; e_head = 0; e_serr = 0; e_lerr = 0; e_sym = 8'h00;
    endtask

    task automatic model_step(input logic v, input logic h, input logic [7:0] d);
        e_oe = 0; e_head = 0; e_serr = 0; e_lerr = 0; e_sym = 8'h00;
        if (v && h) begin
            if (m_in_pkt) begin
                e_lerr = 1; m_prev_ok = 0;
            end
            e_oe = 1; e_head = 1;
            e_sym = m_prev_ok ? m_prev_crc : 8'h00;
            e_serr = (d != 8'h47);
            m_pay.delete();
            m_in_pkt = 1;
        end else if (v) begin
            if (m_in_pkt) begin
                e_oe = 1; e_sym = d;
                m_pay.push_back(d);
                if (m_pay.size() == 187) begin
                    m_prev_crc = crc_of(m_pay);
                    m_prev_ok  = 1;
                    m_in_pkt   = 0;
                end
            end
        end else if (m_in_pkt) begin
            e_lerr = 1; m_prev_ok = 0; m_in_pkt = 0;
        end
    endtask

    task automatic compare_all();
        chk("oe", 8'(oe), 8'(e_oe));
        chk("oe_head", 8'(oe_head), 8'(e_head));
        chk("symbol_out", symbol_out, e_sym);
        chk("sync_err", 8'(sync_err), 8'(e_serr));
        chk("len_err", 8'(len_err), 8'(e_lerr));
    endtask

    task automatic cyc(input logic en, input logic v, input logic h, input logic [7:0] d);
        @(negedge sys_clk);
        fs_en = en; ts_in_vld = v; ts_in_head = h; ts_in_data = d;
        if (en) model_step(v, h, d);
        @(posedge sys_clk);
        #1;
        compare_all();
        if (en) begin
            if (oe === 1'b1 && oe_head === 1'b1) last_head = symbol_out;
            if (sync_err === 1'b1) sync_cnt++;
            if (len_err === 1'b1) len_cnt++;
            if (cont_mon && oe !== 1'b1) gaps++;
        end
    endtask

    task automatic send_byte(input logic v, input logic h, input logic [7:0] d);
        for (int i = 1; i < en_period; i++) cyc(1'b0, v, h, d);
        cyc(1'b1, v, h, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_byte(1'b0, 1'b0, 8'h00);
    endtask

    // kind: 0 zeros, 1 ramp 1..n, 2 random, 3 zeros with last byte 0x01
    task automatic send_pkt(input logic [7:0] hb, input int kind, input int npay);
        logic [7:0] d;
        send_byte(1'b1, 1'b1, hb);
        for (int i = 0; i < npay; i++) begin
            case (kind)
                0:       d = 8'h00;
                1:       d = 8'(i + 1);
                2:       d = 8'($urandom);
                default: d = (i == npay - 1) ? 8'h01 : 8'h00;
            endcase
            send_byte(1'b1, 1'b0, d);
        end
    endtask

    task automatic rand_pkt();
        logic [7:0] hb;
        hb = ($urandom_range(0, 7) == 0) ? 8'h46 : 8'h47;
        if ($urandom_range(0, 5) == 0) begin
            send_pkt(hb, 2, $urandom_range(1, 186));
            if ($urandom_range(0, 1) == 1) idle(1);
        end else begin
            send_pkt(hb, 2, 187);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++)
                send_byte(1'($urandom_range(0, 1)), 1'b0, 8'($urandom));
        end
    endtask

    initial begin
        int s0, l0;
        rst_n = 1'b0; fs_en = 1'b0; ts_in_vld = 1'b0; ts_in_head = 1'b0; ts_in_data = 8'h00;
        last_head = 8'hFF; sync_cnt = 0; len_cnt = 0; gaps = 0; cont_mon = 0; en_period = 1;
        model_reset();
        #12;
        compare_all();
        @(negedge sys_clk);
        rst_n = 1'b1;

        // Zero packet then ramp: both heads carry 0x00
        send_pkt(8'h47, 0, 187);
        send_pkt(8'h47, 1, 187);
        chk("t1_head2_lit", last_head, 8'h00);

        // Payload of zeros ending in 0x01 -> CRC 0xD5
        send_pkt(8'h47, 3, 187);
        send_pkt(8'h47, 2, 187);
        chk("t2_head_d5_lit", last_head, 8'hD5);

        // Continuous generator stream, no gaps
        cont_mon = 1;
        for (int k = 0; k < 3; k++) send_pkt(8'h47, 1, 187);
        send_byte(1'b1, 1'b1, 8'h47);
        cont_mon = 0;
        chk("t3_no_gap", 8'(gaps), 8'h00);
        for (int i = 0; i < 187; i++) send_byte(1'b1, 1'b0, 8'(i + 1));

        // Bad sync byte: one pulse, CRC still propagated
        s0 = sync_cnt;
        send_pkt(8'h46, 2, 187);
        send_pkt(8'h47, 2, 187);
        chk("t4_sync_pulses", 8'(sync_cnt - s0), 8'h01);

        // Valid drop mid-packet
        l0 = len_cnt;
        send_pkt(8'h47, 2, 100);
        idle(1);
        send_pkt(8'h47, 2, 187);
        chk("t5_first_crc_lit", last_head, 8'h00);
        send_pkt(8'h47, 2, 187);
        chk("t5_len_pulses", 8'(len_cnt - l0), 8'h01);

        // Sparse enable with async reset mid-packet
        en_period = 4;
        send_pkt(8'h47, 2, 187);
        send_pkt(8'h47, 2, 90);
        @(negedge sys_clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge sys_clk);
        fs_en = 1'b0; ts_in_vld = 1'b0; ts_in_head = 1'b0; rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        compare_all();
        send_pkt(8'h47, 2, 187);
        chk("t6_post_reset_lit", last_head, 8'h00);
        send_pkt(8'h47, 1, 187);
        en_period = 1;

        // Randomized traffic
        for (int n = 0; n < 24; n++) begin
            en_period = $urandom_range(1, 2);
            rand_pkt();
        end
        en_period = 1;
        send_pkt(8'h47, 2, 5);
        idle(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
